// File: rtl/arbitro_rr_pop_pkg.sv
// Shared definitions for the round-robin pop arbiter.
//   DATA_W          - word width carried from input FIFOs to output FIFOs
//   N_FIFO          - number of input and output FIFOs (fixed at 4)
//   CLS_MSB/CLS_LSB - destination class field inside a word
//   estado_t        - arbiter FSM state encoding
//   class_onehot()  - one-hot output FIFO select for a word
package arbitro_rr_pop_pkg;

  localparam int DATA_W  = 10;
  localparam int N_FIFO  = 4;
  localparam int CLS_MSB = DATA_W - 1;
  localparam int CLS_LSB = DATA_W - 2;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_STALL  = 2'd3
  } estado_t;

  function automatic logic [N_FIFO-1:0] class_onehot(input logic [DATA_W-1:0] word);
    logic [N_FIFO-1:0] oh;
    oh = '0;
    oh[word[CLS_MSB:CLS_LSB]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arbitro_rr_pop_if.sv
// Bus bundle between the arbiter, its four input FIFOs and its four output FIFOs.
//   data_inN     - registered read data of input FIFO N (valid the cycle after popN)
//   emptyN       - input FIFO N empty
//   almost_fullN - output FIFO N has at most 2 free entries
//   popN         - pop strobe to input FIFO N (at most one high)
//   pushN        - push strobe to output FIFO N (at most one high)
//   data_out     - word being pushed
//   estado       - arbiter FSM state
//   idle         - nothing in flight and all inputs empty
// Modports: master = arbiter side, slave = FIFO/environment side.
interface arbitro_rr_pop_if;
  import arbitro_rr_pop_pkg::*;

  logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
  logic              empty0, empty1, empty2, empty3;
  logic              almost_full0, almost_full1, almost_full2, almost_full3;
  logic              pop0, pop1, pop2, pop3;
  logic              push0, push1, push2, push3;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        estado;
  logic              idle;

  modport master (
    input  data_in0, data_in1, data_in2, data_in3,
    input  empty0, empty1, empty2, empty3,
    input  almost_full0, almost_full1, almost_full2, almost_full3,
    output pop0, pop1, pop2, pop3,
    output push0, push1, push2, push3,
    output data_out, estado, idle
  );

  modport slave (
    output data_in0, data_in1, data_in2, data_in3,
    output empty0, empty1, empty2, empty3,
    output almost_full0, almost_full1, almost_full2, almost_full3,
    input  pop0, pop1, pop2, pop3,
    input  push0, push1, push2, push3,
    input  data_out, estado, idle
  );

endinterface

// File: rtl/arbitro_rr_pop_rr_grant4.sv
// 4-way round-robin priority encoder.
//   req[3:0]     - request vector
//   last[1:0]    - index granted most recently; search starts at last+1
//   gnt[3:0]     - one-hot grant, all zero when no request
//   gnt_idx[1:0] - index of the granted request (0 when no grant)
module rr_grant4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_pop.sv
// Round-robin pop arbiter: pops at most one non-empty input FIFO per cycle,
// captures the returned word and pushes it to the output FIFO selected by the
// word's destination class. Pops stop while any output FIFO is almost full;
// words already in flight still complete their push.
//   clk     - clock, all state updates on posedge
//   reset_L - asynchronous active-low reset
//   bus     - arbitro_rr_pop_if.master (FIFO data/status in, pop/push/status out)
//
// state  | meaning
// RESET  | just out of reset, no pops
// IDLE   | all inputs empty last cycle, pops allowed
// ACTIVE | inputs being drained, pops allowed
// STALL  | an output FIFO is almost full, pops blocked
module arbitro_rr_pop
  import arbitro_rr_pop_pkg::*;
(
  input  logic             clk,
  input  logic             reset_L,
  arbitro_rr_pop_if.master bus
);

  estado_t             estado_q;
  logic [1:0]          last_q;
  logic                cap_valid;
  logic [1:0]          cap_sel;
  logic [N_FIFO-1:0]   push_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                idle_q;

  logic [N_FIFO-1:0]   empty_v;
  logic                all_empty;
  logic                af_any;
  logic                pop_en;
  logic [N_FIFO-1:0]   req;
  logic [N_FIFO-1:0]   gnt;
  logic [1:0]          gnt_idx;
  logic                any_gnt;
  logic [DATA_W-1:0]   cap_word;

  assign empty_v   = {bus.empty3, bus.empty2, bus.empty1, bus.empty0};
  assign all_empty = &empty_v;
  assign af_any    = bus.almost_full0 | bus.almost_full1 | bus.almost_full2 | bus.almost_full3;

  // Almost-full blocks the grant in the very cycle it rises; the 2-entry
  // margin downstream absorbs the words already in flight.
  assign pop_en  = ((estado_q == ST_IDLE) || (estado_q == ST_ACTIVE)) && !af_any;
  assign req     = ~empty_v & {N_FIFO{pop_en}};
  assign any_gnt = |gnt;

  rr_grant4 u_grant (
    .req     (req),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Read data of the FIFO popped last cycle is valid now.
  always_comb begin
    cap_word = '0;
    case (cap_sel)
      2'd0:    cap_word = bus.data_in0;
      2'd1:    cap_word = bus.data_in1;
      2'd2:    cap_word = bus.data_in2;
      default: cap_word = bus.data_in3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      estado_q   <= ST_RESET;
      last_q     <= 2'd3;
      cap_valid  <= 1'b0;
      cap_sel    <= 2'd0;
      push_q     <= '0;
      data_out_q <= '0;
      idle_q     <= 1'b0;
    end else begin
      case (estado_q)
        ST_RESET: estado_q <= ST_IDLE;
        ST_IDLE: begin
          if (af_any)          estado_q <= ST_STALL;
          else if (!all_empty) estado_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (af_any)         estado_q <= ST_STALL;
          else if (all_empty) estado_q <= ST_IDLE;
        end
        ST_STALL: begin
          if (!af_any) estado_q <= all_empty ? ST_IDLE : ST_ACTIVE;
        end
        default: estado_q <= ST_RESET;
      endcase

      if (any_gnt) begin
        last_q  <= gnt_idx;
        cap_sel <= gnt_idx;
      end
      cap_valid <= any_gnt;

      // data_out only moves with a push and otherwise keeps the last word.
      if (cap_valid) begin
        push_q     <= class_onehot(cap_word);
        data_out_q <= cap_word;
      end else begin
        push_q     <= '0;
      end

      idle_q <= ((estado_q == ST_IDLE) || (estado_q == ST_STALL)) &&
                all_empty && !cap_valid && (push_q == '0);
    end
  end

  assign bus.pop0     = gnt[0];
  assign bus.pop1     = gnt[1];
  assign bus.pop2     = gnt[2];
  assign bus.pop3     = gnt[3];
  assign bus.push0    = push_q[0];
  assign bus.push1    = push_q[1];
  assign bus.push2    = push_q[2];
  assign bus.push3    = push_q[3];
  assign bus.data_out = data_out_q;
  assign bus.estado   = estado_q;
  assign bus.idle     = idle_q;

endmodule

// File: tb/tb_arbitro_rr_pop.sv
// Directed bench for arbitro_rr_pop: reset, round-robin order, routing,
// backpressure, empty edge, idle timing and asynchronous reset mid-flight.
module tb_arbitro_rr_pop;

  logic clk;
  logic reset_L;
  int   checks;
  int   failures;
  logic [9:0] vals [4];

  arbitro_rr_pop_if bus ();

  arbitro_rr_pop dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pop_v();
    return {28'd0, bus.pop3, bus.pop2, bus.pop1, bus.pop0};
  endfunction

  function automatic logic [31:0] push_v();
    return {28'd0, bus.push3, bus.push2, bus.push1, bus.push0};
  endfunction

  function automatic logic [31:0] est_v();
    return {30'd0, bus.estado};
  endfunction

  function automatic logic [31:0] dout_v();
    return {22'd0, bus.data_out};
  endfunction

  function automatic logic [31:0] idle_v();
    return {31'd0, bus.idle};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // empty vector ordered {empty3, empty2, empty1, empty0}
  task automatic set_empty(input logic [3:0] e);
    bus.empty0 = e[0];
    bus.empty1 = e[1];
    bus.empty2 = e[2];
    bus.empty3 = e[3];
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vals[0] = 10'd140;
    vals[1] = 10'd300;
    vals[2] = 10'd640;
    vals[3] = 10'd900;
    reset_L = 1'b0;
    bus.data_in0 = vals[0];
    bus.data_in1 = vals[1];
    bus.data_in2 = vals[2];
    bus.data_in3 = vals[3];
    set_empty(4'b0000);
    bus.almost_full0 = 1'b0;
    bus.almost_full1 = 1'b0;
    bus.almost_full2 = 1'b0;
    bus.almost_full3 = 1'b0;

    // reset held with all inputs non-empty
    step(); step(); #1;
    chk("rst_pop", pop_v(), 32'd0);
    chk("rst_push", push_v(), 32'd0);
    chk("rst_dout", dout_v(), 32'd0);
    chk("rst_estado", est_v(), 32'd0);
    chk("rst_idle", idle_v(), 32'd0);
    reset_L = 1'b1;

    // first cycle after release: IDLE, pop0 first
    step(); #1;
    chk("rel_estado", est_v(), 32'd1);
    chk("rel_pop0", pop_v(), 32'd1);
    chk("rel_push", push_v(), 32'd0);

    // round robin; pushes trail pops by 2 cycles, class == source index
    for (int k = 1; k < 8; k++) begin
      step(); #1;
      chk("rr_pop", pop_v(), 32'd1 << (k % 4));
      chk("rr_estado", est_v(), 32'd2);
      if (k >= 2) begin
        chk("rr_push", push_v(), 32'd1 << ((k - 2) % 4));
        chk("rr_dout", dout_v(), 32'(vals[(k - 2) % 4]));
      end else begin
        chk("rr_push_none", push_v(), 32'd0);
      end
    end

    // backpressure: almost_full1 blocks the grant in the same cycle
    step(); bus.almost_full1 = 1'b1; #1;
    chk("bp_pop_blocked", pop_v(), 32'd0);
    chk("bp_estado_act", est_v(), 32'd2);
    chk("bp_push_fl1", push_v(), 32'b0100);
    chk("bp_dout_fl1", dout_v(), 32'd640);
    step(); #1;
    chk("bp_estado_stall", est_v(), 32'd3);
    chk("bp_pop_stall", pop_v(), 32'd0);
    chk("bp_push_fl2", push_v(), 32'b1000);
    chk("bp_dout_fl2", dout_v(), 32'd900);
    step(); #1;
    chk("bp_push_drained", push_v(), 32'd0);
    chk("bp_dout_hold", dout_v(), 32'd900);
    step(); bus.almost_full1 = 1'b0; #1;
    chk("bp_pop_still_stall", pop_v(), 32'd0);
    step(); #1;
    chk("bp_resume_estado", est_v(), 32'd2);
    chk("bp_resume_pop0", pop_v(), 32'd1);

    // routing: FIFO2 alone non-empty, word 640 -> push2
    step(); set_empty(4'b1011); #1;
    chk("rt_pop2", pop_v(), 32'b0100);
    chk("rt_push_none", push_v(), 32'd0);
    step(); set_empty(4'b1111); #1;
    chk("rt_no_pop_empty", pop_v(), 32'd0);
    chk("rt_push0", push_v(), 32'b0001);
    chk("rt_dout140", dout_v(), 32'd140);
    step(); #1;
    chk("rt_push2", push_v(), 32'b0100);
    chk("rt_dout640", dout_v(), 32'd640);
    chk("rt_estado_idle", est_v(), 32'd1);
    step(); #1;
    chk("rt_push_off", push_v(), 32'd0);
    chk("rt_dout_hold", dout_v(), 32'd640);
    chk("rt_idle_low", idle_v(), 32'd0);
    step(); #1;
    chk("rt_idle_high", idle_v(), 32'd1);

    // empty edge: FIFO3 for exactly one pop
    step(); set_empty(4'b0111); #1;
    chk("ee_estado_idle", est_v(), 32'd1);
    chk("ee_pop3", pop_v(), 32'b1000);
    step(); set_empty(4'b1111); #1;
    chk("ee_no_pop", pop_v(), 32'd0);
    chk("ee_estado_act", est_v(), 32'd2);
    step(); #1;
    chk("ee_push3", push_v(), 32'b1000);
    chk("ee_dout900", dout_v(), 32'd900);
    chk("ee_estado_back", est_v(), 32'd1);
    chk("ee_idle_0a", idle_v(), 32'd0);
    step(); #1;
    chk("ee_push_off", push_v(), 32'd0);
    chk("ee_idle_0b", idle_v(), 32'd0);
    step(); #1;
    chk("ee_idle_1", idle_v(), 32'd1);

    // asynchronous reset with words in flight
    step(); set_empty(4'b0000); #1;
    chk("ar_pop0", pop_v(), 32'b0001);
    step(); #1;
    chk("ar_pop1", pop_v(), 32'b0010);
    step(); #1;
    chk("ar_push0", push_v(), 32'b0001);
    chk("ar_dout140", dout_v(), 32'd140);
    reset_L = 1'b0; #1;
    chk("ar_push_clr", push_v(), 32'd0);
    chk("ar_dout_clr", dout_v(), 32'd0);
    chk("ar_estado_rst", est_v(), 32'd0);
    chk("ar_pop_rst", pop_v(), 32'd0);
    reset_L = 1'b1;
    step(); #1;
    chk("ar_estado_idle", est_v(), 32'd1);
    chk("ar_no_push_a", push_v(), 32'd0);
    chk("ar_first_pop0", pop_v(), 32'b0001);
    step(); #1;
    chk("ar_no_push_b", push_v(), 32'd0);
    chk("ar_pop1_again", pop_v(), 32'b0010);
    step(); #1;
    chk("ar_push_new", push_v(), 32'b0001);
    chk("ar_dout_new", dout_v(), 32'd140);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
